// File: rtl/slider_digit_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : slider_digit_entry_if
// Description : Slider / operand bundle between the input conditioning
//               stage and the slider_digit_entry block.
// Revision    : 1.0  initial release
// ============================================================================
interface slider_digit_entry_if #(
    parameter int NUM_DIGITS   = 4,
    parameter int NUM_OPERANDS = 2,
    parameter int VALUE_W      = 14
);
    localparam int c_sel_w = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;

    logic [NUM_DIGITS-1:0]           slider;
    logic                            dir;
    logic [c_sel_w-1:0]              operand_sel;
    logic                            clear;
    logic [NUM_OPERANDS*VALUE_W-1:0] operands;
    logic                            step_pulse;
    logic                            at_limit;

    modport master (
        output slider, dir, operand_sel, clear,
        input  operands, step_pulse, at_limit
    );

    modport slave (
        input  slider, dir, operand_sel, clear,
        output operands, step_pulse, at_limit
    );
endinterface
`default_nettype wire

// File: rtl/slider_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : slider_digit_entry
// Description : Slider-driven decimal operand entry with hold/auto-repeat,
//               up/down stepping, saturation and per-operand clear.
// Revision    : 1.0  initial release
// ============================================================================
module slider_digit_entry #(
    parameter int NUM_DIGITS    = 4,
    parameter int NUM_OPERANDS  = 2,
    parameter int VALUE_W       = 14,
    parameter int HOLD_CYCLES   = 32500000,
    parameter int REPEAT_CYCLES = 8125000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    slider_digit_entry_if.slave bus
);
    localparam int c_sel_w = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_tmr_max = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_tmr_w = $clog2(c_tmr_max) + 1;

    function automatic longint pow10(input int k);
        longint p;
        p = 1;
        for (int i = 0; i < k; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    function automatic logic sel_ok(input logic [c_sel_w-1:0] s);
        return int'(s) < NUM_OPERANDS;
    endfunction

    localparam logic [VALUE_W:0]   c_max     = (VALUE_W+1)'(pow10(NUM_DIGITS) - 1);
    localparam logic [c_tmr_w-1:0] c_hold_end = c_tmr_w'(HOLD_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_rep_end  = c_tmr_w'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // Hold/repeat sequencer state
    state_t               r_state;
    state_t               w_nxt_state;
    logic [c_tmr_w-1:0]   r_timer;
    logic [c_tmr_w-1:0]   w_nxt_timer;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_idx_w-1:0]   w_nxt_idx;
    logic                 w_issue;

    // Active slider decode
    logic                 w_any;
    logic [c_idx_w-1:0]   w_active;

    // Step request captured when the sequencer issues, applied one edge later
    logic                 r_req_valid;
    logic [c_idx_w-1:0]   r_req_idx;
    logic                 r_req_dir;
    logic [c_sel_w-1:0]   r_req_sel;

    // Operand datapath
    logic [NUM_OPERANDS*VALUE_W-1:0] r_operands;
    logic                 r_step_pulse;
    logic                 r_at_limit;
    logic [VALUE_W-1:0]   w_old;
    logic [VALUE_W:0]     w_wgt;
    logic [VALUE_W:0]     w_ext;
    logic [VALUE_W:0]     w_sum;
    logic [VALUE_W:0]     w_res;
    logic                 w_clamp;
    logic                 w_clear_ok;
    logic                 w_step_ok;

    // Lowest set slider wins; scan from the top so index 0 is assigned last.
    always_comb begin
        w_any    = |bus.slider;
        w_active = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (bus.slider[i]) begin
                w_active = c_idx_w'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_timer <= w_nxt_timer;
            r_idx   <= w_nxt_idx;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = r_timer;
        w_nxt_idx   = r_idx;
        w_issue     = 1'b0;
        case (r_state)
            S_DELAY, S_REPEAT: begin
                if (!w_any) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_timer = '0;
                end else if (w_active != r_idx) begin
                    // A different digit takes over: behave like a fresh press
                    w_issue     = 1'b1;
                    w_nxt_state = S_DELAY;
                    w_nxt_timer = '0;
                    w_nxt_idx   = w_active;
                end else if ((r_state == S_DELAY) && (r_timer == c_hold_end)) begin
                    w_issue     = 1'b1;
                    w_nxt_state = S_REPEAT;
                    w_nxt_timer = '0;
                end else if ((r_state == S_REPEAT) && (r_timer == c_rep_end)) begin
                    w_issue     = 1'b1;
                    w_nxt_timer = '0;
                end else begin
                    w_nxt_timer = r_timer + 1'b1;
                end
            end
            default: begin
                if (w_any) begin
                    w_issue     = 1'b1;
                    w_nxt_state = S_DELAY;
                    w_nxt_timer = '0;
                    w_nxt_idx   = w_active;
                end
            end
        endcase
    end

    // Saturating step arithmetic, one bit wider than the operand
    always_comb begin
        w_old = '0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (r_req_sel == c_sel_w'(i)) begin
                w_old = r_operands[i*VALUE_W +: VALUE_W];
            end
        end
        w_wgt = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_req_idx == c_idx_w'(k)) begin
                w_wgt = (VALUE_W+1)'(pow10(k));
            end
        end
        w_ext   = {1'b0, w_old};
        w_sum   = w_ext + w_wgt;
        w_res   = '0;
        w_clamp = 1'b0;
        if (!r_req_dir) begin
            if (w_sum > c_max) begin
                w_res   = c_max;
                w_clamp = 1'b1;
            end else begin
                w_res = w_sum;
            end
        end else begin
            if (w_ext >= w_wgt) begin
                w_res = w_ext - w_wgt;
            end else begin
                w_clamp = 1'b1;
            end
        end
    end

    assign w_clear_ok = bus.clear && sel_ok(bus.operand_sel);
    assign w_step_ok  = r_req_valid && sel_ok(r_req_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid  <= 1'b0;
            r_req_idx    <= '0;
            r_req_dir    <= 1'b0;
            r_req_sel    <= '0;
            r_operands   <= '0;
            r_step_pulse <= 1'b0;
            r_at_limit   <= 1'b0;
        end else begin
            r_req_valid  <= w_issue;
            r_req_idx    <= w_active;
            r_req_dir    <= bus.dir;
            r_req_sel    <= bus.operand_sel;
            r_step_pulse <= 1'b0;
            // A clear landing on the same edge as a step wins and drops the step
            if (w_clear_ok) begin
                for (int i = 0; i < NUM_OPERANDS; i++) begin
                    if (bus.operand_sel == c_sel_w'(i)) begin
                        r_operands[i*VALUE_W +: VALUE_W] <= '0;
                    end
                end
                r_at_limit <= 1'b0;
            end else if (w_step_ok) begin
                for (int i = 0; i < NUM_OPERANDS; i++) begin
                    if (r_req_sel == c_sel_w'(i)) begin
                        r_operands[i*VALUE_W +: VALUE_W] <= w_res[VALUE_W-1:0];
                    end
                end
                r_step_pulse <= 1'b1;
                r_at_limit   <= w_clamp;
            end
        end
    end

    assign bus.operands   = r_operands;
    assign bus.step_pulse = r_step_pulse;
    assign bus.at_limit   = r_at_limit;

endmodule
`default_nettype wire

// File: tb/tb_slider_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_slider_digit_entry
// Description : Scoreboard bench for slider_digit_entry (HOLD=10, REPEAT=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_slider_digit_entry;
    localparam int c_vw = 14;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        int sel;
        int val;
        bit lim;
        int cyc;
    } exp_t;

    exp_t sb[$];

    slider_digit_entry_if #(.NUM_DIGITS(4), .NUM_OPERANDS(2), .VALUE_W(c_vw)) sif ();

    slider_digit_entry #(
        .NUM_DIGITS   (4),
        .NUM_OPERANDS (2),
        .VALUE_W      (c_vw),
        .HOLD_CYCLES  (10),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic int opv(int sel);
        return int'(sif.operands[sel*c_vw +: c_vw]);
    endfunction

    // Monitor: every step strobe must match the oldest expected step
    always @(negedge clk) begin
        if (!rst && sif.step_pulse) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL step_unexpected: cycle %0d op0=%0d op1=%0d lim=%0d, no step required",
                         cyc, opv(0), opv(1), sif.at_limit);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (opv(e.sel) != e.val || sif.at_limit != e.lim || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL step_op%0d: got val=%0d lim=%0d cycle=%0d, required val=%0d lim=%0d cycle=%0d",
                             e.sel, opv(e.sel), sif.at_limit, cyc, e.val, e.lim, e.cyc);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_step(input int sel, input int val, input bit lim, input int c);
        exp_t e;
        e.sel = sel;
        e.val = val;
        e.lim = lim;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Single-cycle press; result appears two edges after the inputs are set
    task automatic tap(input logic [3:0] m, input int sel, input bit d, input int val, input bit lim);
        sif.operand_sel = sel[0];
        sif.dir         = d;
        sif.slider      = m;
        expect_step(sel, val, lim, cyc + 2);
        cycles(1);
        sif.slider = '0;
        cycles(3);
    endtask

    initial begin
        int t0;
        n_tests = 0;
        n_fail  = 0;
        rst             = 1'b1;
        sif.slider      = '0;
        sif.dir         = 1'b0;
        sif.operand_sel = '0;
        sif.clear       = 1'b0;
        cycles(3);
        check("reset_operands", int'(sif.operands), 0);
        check("reset_step_pulse", int'(sif.step_pulse), 0);
        check("reset_at_limit", int'(sif.at_limit), 0);
        rst = 1'b0;
        cycles(1);

        // Single tap on weight 1
        tap(4'b0001, 0, 1'b0, 1, 1'b0);
        cycles(2);
        check("tap_op0", opv(0), 1);
        check("tap_op1", opv(1), 0);

        // 20-cycle hold on weight 10: steps at press+1, +11, +15, +19
        t0 = cyc;
        sif.slider = 4'b0010;
        expect_step(0, 11, 1'b0, t0 + 2);
        expect_step(0, 21, 1'b0, t0 + 12);
        expect_step(0, 31, 1'b0, t0 + 16);
        expect_step(0, 41, 1'b0, t0 + 20);
        cycles(20);
        sif.slider = '0;
        cycles(6);
        check("hold_op0", opv(0), 41);

        // Build operand1 = 9980, then saturate upward
        for (int i = 1; i <= 9; i++) tap(4'b1000, 1, 1'b0, i * 1000, 1'b0);
        for (int i = 1; i <= 9; i++) tap(4'b0100, 1, 1'b0, 9000 + i * 100, 1'b0);
        for (int i = 1; i <= 8; i++) tap(4'b0010, 1, 1'b0, 9900 + i * 10, 1'b0);
        t0 = cyc;
        sif.slider = 4'b0010;
        expect_step(1, 9990, 1'b0, t0 + 2);
        expect_step(1, 9999, 1'b1, t0 + 12);
        cycles(11);
        sif.slider = '0;
        cycles(3);
        check("sat_hi_limit", int'(sif.at_limit), 1);
        tap(4'b1000, 1, 1'b1, 8999, 1'b0);
        check("down_op1", opv(1), 8999);
        check("down_limit", int'(sif.at_limit), 0);
        check("untouched_op0", opv(0), 41);

        // Count operand0 down to zero, clamp on the last tap
        tap(4'b0010, 0, 1'b1, 31, 1'b0);
        tap(4'b0010, 0, 1'b1, 21, 1'b0);
        tap(4'b0010, 0, 1'b1, 11, 1'b0);
        tap(4'b0010, 0, 1'b1, 1, 1'b0);
        tap(4'b0010, 0, 1'b1, 0, 1'b1);
        check("sat_lo_limit", int'(sif.at_limit), 1);

        // Clear on the edge of the first auto-repeat step suppresses it
        t0 = cyc;
        sif.slider = 4'b0010;
        expect_step(0, 0, 1'b1, t0 + 2);
        expect_step(0, 0, 1'b1, t0 + 16);
        cycles(11);
        sif.clear = 1'b1;
        cycles(1);
        sif.clear = 1'b0;
        check("clear_limit", int'(sif.at_limit), 0);
        check("clear_pulse", int'(sif.step_pulse), 0);
        cycles(4);
        sif.slider = '0;
        cycles(3);

        // Clear operand1 alone
        sif.operand_sel = 1'b1;
        sif.clear       = 1'b1;
        cycles(1);
        sif.clear = 1'b0;
        check("clear_op1", opv(1), 0);
        check("clear_keeps_op0", opv(0), 0);
        cycles(2);

        // Digit change during DELAY restarts the hold
        sif.operand_sel = 1'b0;
        sif.dir         = 1'b0;
        t0 = cyc;
        sif.slider = 4'b0100;
        expect_step(0, 100, 1'b0, t0 + 2);
        expect_step(0, 101, 1'b0, t0 + 7);
        expect_step(0, 102, 1'b0, t0 + 17);
        cycles(5);
        sif.slider = 4'b0101;
        cycles(12);
        sif.slider = '0;
        cycles(3);
        check("newpress_op0", opv(0), 102);

        // Reset during REPEAT, then the held slider acts as a fresh press
        t0 = cyc;
        sif.slider = 4'b0001;
        expect_step(0, 103, 1'b0, t0 + 2);
        expect_step(0, 104, 1'b0, t0 + 12);
        expect_step(0, 105, 1'b0, t0 + 16);
        cycles(17);
        rst = 1'b1;
        cycles(1);
        check("midhold_rst_operands", int'(sif.operands), 0);
        check("midhold_rst_pulse", int'(sif.step_pulse), 0);
        check("midhold_rst_limit", int'(sif.at_limit), 0);
        rst = 1'b0;
        expect_step(0, 1, 1'b0, cyc + 2);
        cycles(1);
        sif.slider = '0;
        cycles(5);
        check("post_rst_op0", opv(0), 1);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
